// File: rtl/memory_pkg.sv
`default_nettype none
// ============================================================================
// Module      : memory_pkg
// Description : Shared types, limits and byte-merge helper for memory_1r1w_sram.
// Revision    : 1.0 - initial release
// ============================================================================
package memory_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int C_READ_LATENCY_MIN = 1;
    localparam int C_READ_LATENCY_MAX = 2;

    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int C_MAX_DATA_WIDTH = 1024;
    localparam int C_MAX_MASK_WIDTH = C_MAX_DATA_WIDTH / 8;

    function automatic logic latency_ok(input int latency);
        return (latency >= C_READ_LATENCY_MIN) && (latency <= C_READ_LATENCY_MAX);
    endfunction

    function automatic logic [C_MAX_DATA_WIDTH-1:0] mask_merge(
        input logic [C_MAX_DATA_WIDTH-1:0] old_word,
        input logic [C_MAX_DATA_WIDTH-1:0] new_word,
        input logic [C_MAX_MASK_WIDTH-1:0] mask
    );
        logic [C_MAX_DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < C_MAX_MASK_WIDTH; i++) begin
            if (mask[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage : memory_pkg
`default_nettype wire

// File: rtl/memory_1r1w_array.sv
`default_nettype none
// ============================================================================
// Module      : memory_1r1w_array
// Description : Storage array with byte-masked write port and a registered
//               (latency-1, read-first) read port returning 0 out of range.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_1r1w_array
    import memory_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wen,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [MASK_WIDTH-1:0] i_wmask,
    input  logic                  i_ren,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  w_wr_in_range;
    logic                  w_rd_in_range;
    logic [DATA_WIDTH-1:0] w_wr_word;

    assign w_wr_in_range = int'(i_waddr) < DEPTH;
    assign w_rd_in_range = int'(i_raddr) < DEPTH;

    assign w_wr_word = DATA_WIDTH'(mask_merge(C_MAX_DATA_WIDTH'(r_mem[i_waddr]),
                                              C_MAX_DATA_WIDTH'(i_wdata),
                                              C_MAX_MASK_WIDTH'(i_wmask)));

    // Contents are initialised by the clear sequencer, not by reset.
    always_ff @(posedge clk) begin
        if (i_wen && w_wr_in_range) begin
            r_mem[i_waddr] <= w_wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_ren) begin
            r_rdata <= w_rd_in_range ? r_mem[i_raddr] : '0;
        end
    end

    assign o_rdata = r_rdata;

endmodule : memory_1r1w_array
`default_nettype wire

// File: rtl/memory_1r1w_sram.sv
`default_nettype none
// ============================================================================
// Module      : memory_1r1w_sram
// Description : 1R1W synchronous RAM with byte masks, post-reset clear and
//               READ_LATENCY of 1 or 2. Define MEMORY_1R1W_SRAM_BYPASS_EN for
//               write-first same-address forwarding (read-first otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module memory_1r1w_sram
    import memory_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int DEPTH        = 32,
    parameter int ADDR_WIDTH   = $clog2(DEPTH),
    parameter int READ_LATENCY = 1,
    parameter int MASK_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  ready,
    input  logic                  ren,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic                  rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [MASK_WIDTH-1:0] wmask
);

    localparam logic [ADDR_WIDTH-1:0] c_last_entry = ADDR_WIDTH'(DEPTH - 1);

    generate
        if (!latency_ok(READ_LATENCY)) begin : g_bad_latency
            $error("memory_1r1w_sram: READ_LATENCY must be 1 or 2");
        end
        if ((DATA_WIDTH % 8 != 0) || (DATA_WIDTH > C_MAX_DATA_WIDTH) || (DEPTH < 2)) begin : g_bad_shape
            $error("memory_1r1w_sram: illegal DATA_WIDTH or DEPTH");
        end
    endgenerate

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic [ADDR_WIDTH-1:0] w_clr_cnt_nxt;
    logic                  w_run;

    logic                  w_arr_wen;
    logic [ADDR_WIDTH-1:0] w_arr_waddr;
    logic [DATA_WIDTH-1:0] w_arr_wdata;
    logic [MASK_WIDTH-1:0] w_arr_wmask;
    logic [DATA_WIDTH-1:0] w_arr_rdata;
    logic                  w_ren_acc;

    logic                  r_valid1;
    logic [DATA_WIDTH-1:0] w_rd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    // While clearing, the sequencer owns the write port and requests are ignored.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_run         = 1'b0;
        w_arr_wen     = wen;
        w_arr_waddr   = waddr;
        w_arr_wdata   = wdata;
        w_arr_wmask   = wmask;
        case (r_state)
            CLEAR: begin
                w_arr_wen   = 1'b1;
                w_arr_waddr = r_clr_cnt;
                w_arr_wdata = '0;
                w_arr_wmask = '1;
                if (r_clr_cnt == c_last_entry) begin
                    w_state_nxt   = RUN;
                    w_clr_cnt_nxt = '0;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                end
            end
            RUN: begin
                w_run = 1'b1;
            end
            default: begin
                w_state_nxt   = CLEAR;
                w_clr_cnt_nxt = '0;
            end
        endcase
    end

    assign ready     = w_run;
    assign w_ren_acc = w_run && ren;

    memory_1r1w_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MASK_WIDTH (MASK_WIDTH)
    ) u_array (
        .clk     (clock),
        .rst     (reset),
        .i_wen   (w_arr_wen),
        .i_waddr (w_arr_waddr),
        .i_wdata (w_arr_wdata),
        .i_wmask (w_arr_wmask),
        .i_ren   (w_ren_acc),
        .i_raddr (raddr),
        .o_rdata (w_arr_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid1 <= 1'b0;
        end else begin
            r_valid1 <= w_ren_acc;
        end
    end

`ifdef MEMORY_1R1W_SRAM_BYPASS_EN
    logic                  r_fwd_hit;
    logic [DATA_WIDTH-1:0] r_fwd_data;
    logic [MASK_WIDTH-1:0] r_fwd_mask;
    logic                  w_collide;

    assign w_collide = w_ren_acc && wen && (waddr == raddr) && (int'(waddr) < DEPTH);

    // Array returns the pre-write word; the captured write bytes are overlaid on it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fwd_hit  <= 1'b0;
            r_fwd_data <= '0;
            r_fwd_mask <= '0;
        end else if (w_ren_acc) begin
            r_fwd_hit  <= w_collide;
            r_fwd_data <= wdata;
            r_fwd_mask <= wmask;
        end
    end

    assign w_rd1 = r_fwd_hit ? DATA_WIDTH'(mask_merge(C_MAX_DATA_WIDTH'(w_arr_rdata),
                                                      C_MAX_DATA_WIDTH'(r_fwd_data),
                                                      C_MAX_MASK_WIDTH'(r_fwd_mask)))
                             : w_arr_rdata;
`else
    assign w_rd1 = w_arr_rdata;
`endif

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            assign rvalid = r_valid1;
            assign rdata  = w_rd1;
        end else begin : g_lat2
            logic                  r_valid2;
            logic [DATA_WIDTH-1:0] r_rdata2;

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_valid2 <= 1'b0;
                    r_rdata2 <= '0;
                end else begin
                    r_valid2 <= r_valid1;
                    if (r_valid1) begin
                        r_rdata2 <= w_rd1;
                    end
                end
            end

            assign rvalid = r_valid2;
            assign rdata  = r_rdata2;
        end
    endgenerate

endmodule : memory_1r1w_sram
`default_nettype wire

// File: tb/tb_memory_1r1w_sram.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_1r1w_sram
// Description : Two instances (DEPTH 32 / latency 1 and DEPTH 24 / latency 2)
//               driven in parallel and compared against an array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_1r1w_sram;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ren   = 1'b0;
    logic        wen   = 1'b0;
    logic [4:0]  raddr = '0;
    logic [4:0]  waddr = '0;
    logic [63:0] wdata = '0;
    logic [7:0]  wmask = '0;

    logic [1:0]  obs_ready;
    logic [1:0]  obs_valid;
    logic [63:0] obs_data0;
    logic [63:0] obs_data1;

    always #5 clock = ~clock;

    memory_1r1w_sram #(
        .DATA_WIDTH(64), .DEPTH(32), .READ_LATENCY(1)
    ) u_dut0 (
        .clock(clock), .reset(reset), .ready(obs_ready[0]),
        .ren(ren), .raddr(raddr), .rvalid(obs_valid[0]), .rdata(obs_data0),
        .wen(wen), .waddr(waddr), .wdata(wdata), .wmask(wmask)
    );

    memory_1r1w_sram #(
        .DATA_WIDTH(64), .DEPTH(24), .READ_LATENCY(2)
    ) u_dut1 (
        .clock(clock), .reset(reset), .ready(obs_ready[1]),
        .ren(ren), .raddr(raddr), .rvalid(obs_valid[1]), .rdata(obs_data1),
        .wen(wen), .waddr(waddr), .wdata(wdata), .wmask(wmask)
    );

    logic [63:0] mdl_mem [2][32];
    logic        exp_v   [2][4];
    logic [63:0] exp_d   [2][4];
    logic [63:0] last_d  [2];
    int          edge_n   = 0;
    int          rst_edge = 0;
    int          tests    = 0;
    int          fails    = 0;

    function automatic int dep(input int i);
        return (i == 0) ? 32 : 24;
    endfunction

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    // Apply the spec rules for the edge just taken, using the inputs held during it.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                rst_edge = edge_n;
                for (int k = 0; k < 4; k++) exp_v[i][k] = 1'b0;
                for (int a = 0; a < 32; a++) mdl_mem[i][a] = '0;
                last_d[i] = '0;
            end else if (edge_n - 1 >= rst_edge + dep(i)) begin
                logic [63:0] rd;
                int          slot;
                if (ren) begin
                    rd = '0;
                    if (int'(raddr) < dep(i)) begin
                        rd = mdl_mem[i][raddr];
`ifdef MEMORY_1R1W_SRAM_BYPASS_EN
                        if (wen && (waddr == raddr)) begin
                            for (int b = 0; b < 8; b++)
                                if (wmask[b]) rd[8*b +: 8] = wdata[8*b +: 8];
                        end
`endif
                    end
                    slot = (edge_n + lat(i) - 1) % 4;
                    exp_v[i][slot] = 1'b1;
                    exp_d[i][slot] = rd;
                end
                if (wen && (int'(waddr) < dep(i))) begin
                    for (int b = 0; b < 8; b++)
                        if (wmask[b]) mdl_mem[i][waddr][8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            int          slot;
            logic        ev;
            logic        er;
            logic [63:0] od;
            slot = edge_n % 4;
            ev   = exp_v[i][slot];
            if (ev) last_d[i] = exp_d[i][slot];
            exp_v[i][slot] = 1'b0;
            er = (edge_n >= rst_edge + dep(i));
            od = (i == 0) ? obs_data0 : obs_data1;
            tests++;
            assert (obs_ready[i] === er) else begin
                fails++;
                $error("FAIL ready inst%0d edge%0d observed=%0b expected=%0b", i, edge_n, obs_ready[i], er);
            end
            tests++;
            assert (obs_valid[i] === ev) else begin
                fails++;
                $error("FAIL rvalid inst%0d edge%0d observed=%0b expected=%0b", i, edge_n, obs_valid[i], ev);
            end
            tests++;
            assert (od === last_d[i]) else begin
                fails++;
                $error("FAIL rdata inst%0d edge%0d observed=%h expected=%h", i, edge_n, od, last_d[i]);
            end
        end
    endtask

    task automatic step(input logic r_en, input logic [4:0] ra, input logic w_en,
                        input logic [4:0] wa, input logic [63:0] wd, input logic [7:0] wm);
        ren   = r_en;
        raddr = ra;
        wen   = w_en;
        waddr = wa;
        wdata = wd;
        wmask = wm;
        @(posedge clock);
        edge_n++;
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 5'd0, 1'b0, 5'd0, 64'd0, 8'd0);
    endtask

    task automatic wait_ready();
        while (edge_n < rst_edge + 32) idle(1);
    endtask

    task automatic random_steps(input int n);
        for (int k = 0; k < n; k++) begin
            logic [4:0] ra;
            logic [4:0] wa;
            ra = 5'($urandom_range(0, 31));
            wa = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
            step(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), wa,
                 {$urandom, $urandom}, 8'($urandom));
        end
    endtask

    initial begin
        // Reset values
        idle(3);
        reset = 1'b0;
        // Requests during the clear sequence must be ignored
        for (int k = 0; k < 20; k++)
            step(1'b1, 5'(k), 1'b1, 5'(k), 64'hFFFF_0000_FFFF_0000, 8'hFF);
        wait_ready();
        // Every address reads zero after clear
        for (int a = 0; a < 32; a++) step(1'b1, 5'(a), 1'b0, 5'd0, 64'd0, 8'd0);
        idle(2);
        // Byte-masked write
        step(1'b0, 5'd0, 1'b1, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        step(1'b0, 5'd0, 1'b1, 5'd3, 64'h1122_3344_5566_7788, 8'h0F);
        step(1'b1, 5'd3, 1'b0, 5'd0, 64'd0, 8'd0);
        idle(2);
        // Same-address collision, then a plain read
        step(1'b0, 5'd0, 1'b1, 5'd5, 64'hA, 8'hFF);
        step(1'b1, 5'd5, 1'b1, 5'd5, 64'hB, 8'hFF);
        step(1'b1, 5'd5, 1'b0, 5'd0, 64'd0, 8'd0);
        // Partial-mask collision and a zero-mask write
        step(1'b1, 5'd5, 1'b1, 5'd5, 64'h0102_0304_0506_0708, 8'hA5);
        step(1'b1, 5'd5, 1'b1, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
        idle(3);
        // Back-to-back streaming reads
        for (int a = 0; a < 4; a++) step(1'b1, 5'(a), 1'b0, 5'd0, 64'd0, 8'd0);
        idle(3);
        // Out-of-range write and reads (inst1 has DEPTH 24)
        step(1'b0, 5'd0, 1'b1, 5'd23, 64'h2323_2323_2323_2323, 8'hFF);
        step(1'b0, 5'd0, 1'b1, 5'd30, 64'h3030_3030_3030_3030, 8'hFF);
        step(1'b1, 5'd30, 1'b0, 5'd0, 64'd0, 8'd0);
        step(1'b1, 5'd23, 1'b0, 5'd0, 64'd0, 8'd0);
        idle(3);
        random_steps(300);
        idle(3);
        // Reset while reads are in flight
        step(1'b0, 5'd0, 1'b1, 5'd7, 64'hDEAD_BEEF_0123_4567, 8'hFF);
        step(1'b1, 5'd7, 1'b0, 5'd0, 64'd0, 8'd0);
        step(1'b1, 5'd7, 1'b0, 5'd0, 64'd0, 8'd0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        wait_ready();
        step(1'b1, 5'd7, 1'b0, 5'd0, 64'd0, 8'd0);
        idle(3);
        random_steps(150);
        idle(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_memory_1r1w_sram
`default_nettype wire

// File: doc/memory_1r1w_sram.md
# memory_1r1w_sram

Parametrised single-read, single-write synchronous memory with byte-masked writes, configurable read latency, a post-reset clear sequencer and optional read-during-write forwarding. It is the next generation of the project's 1R1W register-file/memory macro. Cores and buffers instantiate it wherever a small on-chip RAM needs known contents after reset and a valid-qualified read port.

## Interface
Parameters:
- DATA_WIDTH, 64: bits per word; must be a multiple of 8.
- DEPTH, 32: number of words; need not be a power of two; minimum 2.
- ADDR_WIDTH, $clog2(DEPTH): address bits.
- READ_LATENCY, 1: cycles from accepted read to rvalid/rdata; legal values are 1 and 2.
- MASK_WIDTH, DATA_WIDTH/8: byte-enable bits.

Ports:
- clock  input  1  single clock; every register updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- ready  output  1  high once the clear sequence has finished; requests are accepted only while it is high.
- ren  input  1  read request.
- raddr  input  ADDR_WIDTH  read address.
- rvalid  output  1  rdata carries the result of a read accepted READ_LATENCY cycles earlier.
- rdata  output  DATA_WIDTH  read data; holds its last value while rvalid is low.
- wen  input  1  write request.
- waddr  input  ADDR_WIDTH  write address.
- wdata  input  DATA_WIDTH  write data.
- wmask  input  MASK_WIDTH  byte enables; bit i covers wdata[8i+7:8i].

## Operation
- State machine has two states, CLEAR and RUN.
  - reset forces CLEAR with clr_cnt = 0.
  - In CLEAR, each cycle writes all-zero to entry clr_cnt, then increments clr_cnt.
  - When clr_cnt reaches DEPTH-1, the state moves to RUN on the same edge that writes the last entry.
- While in CLEAR, ready = 0 and ren/wen are ignored: no write occurs and rvalid is never produced.
- Write in RUN: when wen = 1 and waddr < DEPTH, each byte whose wmask bit is 1 takes the new wdata value; the other bytes are unchanged. wmask = 0 is a no-op.
- Read in RUN: when ren = 1, the read is accepted. If raddr >= DEPTH, the returned data is 0.
- Simultaneous read and write to different addresses are independent.
- Same address in the same cycle: behaviour is set by the macro in Configuration.
- Out-of-range writes (waddr >= DEPTH) are dropped silently.
- If reset is asserted mid-operation, any reads in flight are squashed (no rvalid) and the clear sequence restarts from entry 0.

## Timing
- Reset values: ready = 0, rvalid = 0, rdata = 0; internal state = CLEAR, clr_cnt = 0.
- Clear sequence: let cycle 0 be the first cycle with reset low. Entries 0 through DEPTH-1 are cleared in cycles 0 through DEPTH-1, and ready = 1 from cycle DEPTH onward.
- READ_LATENCY = 1: a read accepted in cycle t gives rvalid = 1 and rdata in cycle t+1.
- READ_LATENCY = 2: the same data passes through one extra output register and appears in cycle t+2.
- Back-to-back reads are supported at one per cycle, so rvalid can stay high continuously.
- A write in cycle t is visible to any read accepted in cycle t+1 or later.
- rdata reflects the array contents at acceptance time t, plus any forwarding. A write in cycle t+1 does not change a result that is still in flight in the latency-2 stage.

## Configuration
- Macro: MEMORY_1R1W_SRAM_BYPASS_EN.
- Defined (write-first): a same-cycle read and write to the same in-range address returns the new data.
  - Bytes with wmask = 1 come from wdata.
  - Bytes with wmask = 0 come from the old word.
- Undefined (read-first): the same collision returns the old word, i.e. the contents before the write.
- Out-of-range collisions return 0 in both modes.

## Structure
- Shared package memory_pkg holds:
  - the state enum (CLEAR, RUN);
  - the function mask_merge(old, new, mask) for byte-masked merging, used by both the write path and forwarding;
  - the legal READ_LATENCY limits, with an elaboration-time check.
- One sub-module, memory_1r1w_array, contains:
  - the storage array;
  - the masked write port;
  - the registered read port with latency 1.
- The top level contains the clear sequencer, the valid pipeline, the forwarding mux and the optional second output stage.

## Test plan
- Clear: DEPTH = 32; release reset, then read every address once ready = 1 → ready first high in cycle 32, and all 32 reads return 0x0, each with rvalid one cycle after ren.
- Masked write: write 0xFFFF_FFFF_FFFF_FFFF to addr 3, then write 0x1122_3344_5566_7788 with wmask = 0x0F → reading addr 3 returns 0xFFFF_FFFF_5566_7788.
- Collision: addr 5 holds 0xA; in one cycle, write 0xB with full mask and read addr 5 → returns 0xB with the macro defined and 0xA without it. A subsequent read returns 0xB in both modes.
- Latency and streaming:
  - READ_LATENCY = 2, ren high for 4 cycles at addrs 0–3 → rvalid is high for exactly 4 cycles starting 2 cycles later, with data in order.
  - Requests issued while ready = 0 produce no rvalid.
- Reset mid-operation: assert reset for 1 cycle while 2 reads are in flight → neither read produces rvalid, ready drops to 0, previously written data reads back as 0 after ready returns, and ready returns DEPTH cycles after reset falls.
- Out-of-range: DEPTH = 24; write to addr 30, then read addr 30 and read addr 23 → addr 30 reads 0 and addr 23 is unchanged.
